// File: rtl/pipeline_controller.sv
// Central sequencer for the 5-stage pipeline: stage enables/flushes, halt/drain FSM,
// saturating stall/flush counters and a sticky data-memory timeout error.
module pipeline_controller #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_use_stall,
    input  logic        i_branch_taken,
    input  logic        i_halt_id,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    input  logic        i_resume,
    input  logic        i_clr_counts,
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_idex_en,
    output logic        o_exmem_en,
    output logic        o_memwb_en,
    output logic        o_halted,
    output logic        o_mem_timeout,
    output logic [15:0] o_stall_count,
    output logic [7:0]  o_flush_count
);

    localparam int unsigned DW = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned FW = 8;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [FW-1:0] flush_q, flush_d;

    logic mem_freeze;
    logic tmo_hit;
    logic use_run;
    logic stall_inc, flush_inc;

    logic pc_en, ifid_en, ifid_flush, idex_flush, idex_en, exmem_en, memwb_en;

    logic r_pc_en, r_ifid_en, r_ifid_flush, r_idex_flush;
    logic r_stall, r_flush, r_halt;

    assign mem_freeze = i_mem_req & ~i_mem_ready;
    // True when this further wait cycle brings the wait length to MEM_TIMEOUT
    assign tmo_hit = ({1'b0, tmo_q} + (TW+1)'(1)) >= (TW+1)'(MEM_TIMEOUT);

    // Normal-flow priority: branch squashes load-use and halt, load-use beats halt
    always_comb begin : run_rules
        r_pc_en      = 1'b1;
        r_ifid_en    = 1'b1;
        r_ifid_flush = 1'b0;
        r_idex_flush = 1'b0;
        r_stall      = 1'b0;
        r_flush      = 1'b0;
        r_halt       = 1'b0;
        if (i_branch_taken) begin
            r_ifid_flush = 1'b1;
            r_idex_flush = 1'b1;
            r_flush      = 1'b1;
        end else if (i_load_use_stall) begin
            r_pc_en      = 1'b0;
            r_ifid_en    = 1'b0;
            r_idex_flush = 1'b1;
            r_stall      = 1'b1;
        end else if (i_halt_id) begin
            r_pc_en      = 1'b0;
            r_ifid_en    = 1'b0;
            r_idex_flush = 1'b1;
            r_halt       = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        drain_d    = drain_q;
        tmo_d      = tmo_q;
        timeout_d  = timeout_q;
        use_run    = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_freeze) begin
                    state_d   = ST_MEM_WAIT;
                    tmo_d     = TW'(1);
                    stall_inc = 1'b1;
                end else begin
                    use_run = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_ready) begin
                    use_run = 1'b1;
                end else begin
                    tmo_d     = tmo_q + TW'(1);
                    stall_inc = 1'b1;
                    if (tmo_hit) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALTED;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_freeze) begin
                    tmo_d     = tmo_q + TW'(1);
                    stall_inc = 1'b1;
                    if (tmo_hit) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALTED;
                    end
                end else begin
                    tmo_d      = '0;
                    idex_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    drain_d    = drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (i_resume && !timeout_q) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (use_run) begin
            pc_en      = r_pc_en;
            ifid_en    = r_ifid_en;
            ifid_flush = r_ifid_flush;
            idex_flush = r_idex_flush;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            stall_inc  = r_stall;
            flush_inc  = r_flush;
            tmo_d      = '0;
            if (r_halt) begin
                state_d = ST_DRAIN;
                drain_d = DW'(DRAIN_CYCLES);
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Clear wins over increment; both counters stick at all-ones
    always_comb begin : counters_next
        stall_d = stall_q;
        flush_d = flush_q;
        if (i_clr_counts) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall_inc && (stall_q != '1)) begin
                stall_d = stall_q + SW'(1);
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_d = flush_q + FW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_regs
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // Enables and flushes are forced low while reset is held
    assign o_pc_en       = pc_en      & i_rst_n;
    assign o_ifid_en     = ifid_en    & i_rst_n;
    assign o_ifid_flush  = ifid_flush & i_rst_n;
    assign o_idex_flush  = idex_flush & i_rst_n;
    assign o_idex_en     = idex_en    & i_rst_n;
    assign o_exmem_en    = exmem_en   & i_rst_n;
    assign o_memwb_en    = memwb_en   & i_rst_n;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_mem_timeout = timeout_q;
    assign o_stall_count = stall_q;
    assign o_flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized and directed checks of pipeline_controller against a cycle-level behavioural model.
module tb_pipeline_controller;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned MEM_TIMEOUT  = 16;

    localparam logic [6:0] CTL_NORMAL = 7'b1111100;
    localparam logic [6:0] CTL_BRANCH = 7'b1111111;
    localparam logic [6:0] CTL_BUBBLE = 7'b0011101;
    localparam logic [6:0] CTL_FROZEN = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_load_use_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic        i_halt_id = 1'b0;
    logic        i_mem_req = 1'b0;
    logic        i_mem_ready = 1'b0;
    logic        i_resume = 1'b0;
    logic        i_clr_counts = 1'b0;
    logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush;
    logic        o_idex_en, o_exmem_en, o_memwb_en;
    logic        o_halted, o_mem_timeout;
    logic [15:0] o_stall_count;
    logic [7:0]  o_flush_count;
    logic [6:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

    // Model: where the core is, how long the current memory wait is, counters as plain ints
    bit m_halted, m_draining, m_waiting, m_err;
    int m_drain_left, m_wait_len, m_stalls, m_flushes;

    always #5 clk = ~clk;

    pipeline_controller #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_load_use_stall(i_load_use_stall),
        .i_branch_taken  (i_branch_taken),
        .i_halt_id       (i_halt_id),
        .i_mem_req       (i_mem_req),
        .i_mem_ready     (i_mem_ready),
        .i_resume        (i_resume),
        .i_clr_counts    (i_clr_counts),
        .o_pc_en         (o_pc_en),
        .o_ifid_en       (o_ifid_en),
        .o_ifid_flush    (o_ifid_flush),
        .o_idex_flush    (o_idex_flush),
        .o_idex_en       (o_idex_en),
        .o_exmem_en      (o_exmem_en),
        .o_memwb_en      (o_memwb_en),
        .o_halted        (o_halted),
        .o_mem_timeout   (o_mem_timeout),
        .o_stall_count   (o_stall_count),
        .o_flush_count   (o_flush_count)
    );

    assign ctl = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_ifid_flush, o_idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted     = 1'b0;
        m_draining   = 1'b0;
        m_waiting    = 1'b0;
        m_err        = 1'b0;
        m_drain_left = 0;
        m_wait_len   = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    // One clock cycle: drive, predict, compare, clock, advance model. Entered just after a rising edge.
    task automatic step(input bit lu, input bit br, input bit hlt, input bit req,
                        input bit rdy, input bit res, input bit clr);
        logic [6:0] exp_ctl;
        bit frz;
        bit n_halted, n_draining, n_waiting, n_err;
        int n_left, n_wlen, s_inc, f_inc;
        i_load_use_stall = lu;
        i_branch_taken   = br;
        i_halt_id        = hlt;
        i_mem_req        = req;
        i_mem_ready      = rdy;
        i_resume         = res;
        i_clr_counts     = clr;
        frz        = req && !rdy;
        exp_ctl    = CTL_FROZEN;
        s_inc      = 0;
        f_inc      = 0;
        n_halted   = m_halted;
        n_draining = m_draining;
        n_waiting  = m_waiting;
        n_err      = m_err;
        n_left     = m_drain_left;
        n_wlen     = m_wait_len;
        if (m_halted) begin
            if (res && !m_err) n_halted = 1'b0;
        end else if ((m_draining && frz) || (m_waiting && !rdy) || (!m_draining && !m_waiting && frz)) begin
            // memory freeze: wait grows by one cycle, times out at MEM_TIMEOUT cycles
            n_wlen  = m_wait_len + 1;
            s_inc   = 1;
            n_waiting = !m_draining;
            if (n_wlen >= MEM_TIMEOUT) begin
                n_err      = 1'b1;
                n_halted   = 1'b1;
                n_waiting  = 1'b0;
                n_draining = 1'b0;
            end
        end else if (m_draining) begin
            exp_ctl = CTL_BUBBLE;
            n_wlen  = 0;
            n_left  = m_drain_left - 1;
            if (n_left == 0) begin
                n_draining = 1'b0;
                n_halted   = 1'b1;
            end
        end else begin
            n_waiting = 1'b0;
            n_wlen    = 0;
            if (br) begin
                exp_ctl = CTL_BRANCH;
                f_inc   = 1;
            end else if (lu) begin
                exp_ctl = CTL_BUBBLE;
                s_inc   = 1;
            end else if (hlt) begin
                exp_ctl    = CTL_BUBBLE;
                n_draining = 1'b1;
                n_left     = DRAIN_CYCLES;
            end else begin
                exp_ctl = CTL_NORMAL;
            end
        end
        #2;
        chk("ctl", 32'(ctl), 32'(exp_ctl));
        chk("halted", 32'(o_halted), 32'(m_halted));
        chk("mem_timeout", 32'(o_mem_timeout), 32'(m_err));
        chk("stall_count", 32'(o_stall_count), 32'(m_stalls));
        chk("flush_count", 32'(o_flush_count), 32'(m_flushes));
        @(posedge clk);
        m_halted     = n_halted;
        m_draining   = n_draining;
        m_waiting    = n_waiting;
        m_err        = n_err;
        m_drain_left = n_left;
        m_wait_len   = n_wlen;
        if (clr) begin
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            m_stalls  = (m_stalls + s_inc > 65535) ? 65535 : m_stalls + s_inc;
            m_flushes = (m_flushes + f_inc > 255) ? 255 : m_flushes + f_inc;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges must take effect with no clock edge
    task automatic async_reset();
        i_load_use_stall = 1'b0;
        i_branch_taken   = 1'b0;
        i_halt_id        = 1'b0;
        i_mem_req        = 1'b0;
        i_mem_ready      = 1'b0;
        i_resume         = 1'b0;
        i_clr_counts     = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(CTL_FROZEN));
        chk("rst_halted", 32'(o_halted), 32'd0);
        chk("rst_timeout", 32'(o_mem_timeout), 32'd0);
        chk("rst_stall", 32'(o_stall_count), 32'd0);
        chk("rst_flush", 32'(o_flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        i_branch_taken = 1'b1;
        #3;
        chk("por_ctl", 32'(ctl), 32'(CTL_FROZEN));
        chk("por_counts", 32'({o_stall_count, o_flush_count}), 32'd0);
        i_branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle in RUN
        idle(3);
        chk("idle_ctl", 32'(ctl), 32'(CTL_NORMAL));

        // Single load-use stall
        step(1, 0, 0, 0, 0, 0, 0);
        chk("lu_stall_count", 32'(o_stall_count), 32'd1);
        idle(1);

        // Branch squashes load-use and halt
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("br_flush_count", 32'(o_flush_count), 32'd1);
        chk("br_stall_count", 32'(o_stall_count), 32'd0);
        idle(2);
        chk("br_still_run", 32'(ctl), 32'(CTL_NORMAL));

        // Four-cycle memory stall then ready
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("mem4_stall_count", 32'(o_stall_count), 32'd4);
        chk("mem4_no_timeout", 32'(o_mem_timeout), 32'd0);
        idle(1);

        // Halt, drain, resume
        step(0, 0, 1, 0, 0, 0, 0);
        idle(DRAIN_CYCLES);
        chk("drain_halted", 32'(o_halted), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("resume_run", 32'(o_halted), 32'd0);
        idle(1);

        // Halt with a two-cycle memory stall mid-drain
        step(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        idle(1);
        chk("drain_stall_not_yet", 32'(o_halted), 32'd0);
        idle(1);
        chk("drain_stall_halted", 32'(o_halted), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Flush counter saturation, then clear beats increment
        for (int i = 0; i < 260; i++) step(0, 1, 0, 0, 0, 0, 0);
        chk("flush_saturate", 32'(o_flush_count), 32'hFF);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("clr_priority", 32'(o_flush_count), 32'd0);

        // Memory timeout is sticky and blocks resume
        for (int i = 0; i < int'(MEM_TIMEOUT); i++) step(0, 0, 0, 1, 0, 0, 0);
        chk("timeout_set", 32'(o_mem_timeout), 32'd1);
        chk("timeout_halted", 32'(o_halted), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("timeout_resume_blocked", 32'(o_halted), 32'd1);
        async_reset();
        idle(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit lu, br, hlt, req, rdy, res, clr;
            lu  = ($urandom_range(99) < 15);
            br  = ($urandom_range(99) < 15);
            hlt = ($urandom_range(99) < 5);
            req = ($urandom_range(99) < 30);
            rdy = ($urandom_range(99) < 60);
            res = ($urandom_range(99) < 20);
            clr = ($urandom_range(99) < 2);
            if ($urandom_range(999) < 3) async_reset();
            else step(lu, br, hlt, req, rdy, res, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
